// File: rtl/multiplicador_algoritmico.sv
// Sequential shift-add multiplier that rebuilds Num = Coc*Den + Res.
// Works on operand magnitudes and applies the sign in a final fix-up cycle.
// It uses a level Start / level Done handshake:
//   - Start is sampled only in IDLE.
//   - Done stays high in DONE for as long as Start is held.
//   - The first edge that sees Start low returns the block to IDLE.
// Num and Ovf are registered and change only in FIX or on reset.
module multiplicador_algoritmico #(
  parameter int tamanyo = 16
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start,
  input  logic [tamanyo-1:0]     Coc,
  input  logic [tamanyo-1:0]     Den,
  input  logic [tamanyo-1:0]     Res,
  output logic [2*tamanyo-1:0]   Num,
  output logic                   Done,
  output logic                   Ovf,
  output logic [1:0]             dbg_state
);

  localparam int CW = $clog2(tamanyo) + 1;
  localparam logic [CW-1:0] last_iter = CW'(tamanyo - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [2*tamanyo-1:0] mcand;
  logic [tamanyo-1:0]   mplr;
  logic [2*tamanyo-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 sign_q;
  logic [tamanyo-1:0]   res_q;

  logic [tamanyo-1:0]   coc_mag;
  logic [tamanyo-1:0]   den_mag;
  logic [2*tamanyo-1:0] acc_signed;
  logic [2*tamanyo-1:0] res_ext;
  logic [2*tamanyo-1:0] fix_sum;
  logic [tamanyo:0]     fix_top;
  logic                 fix_ovf;

  // Unsigned magnitudes. Note that abs(-2^(n-1)) = 2^(n-1) still fits in n bits.
  assign coc_mag = Coc[tamanyo-1] ? (~Coc + 1'b1) : Coc;
  assign den_mag = Den[tamanyo-1] ? (~Den + 1'b1) : Den;

  // Fix-up arithmetic. The result fits in tamanyo signed bits only when
  // the top tamanyo+1 bits are all equal.
  assign acc_signed = sign_q ? (~acc + 1'b1) : acc;
  assign res_ext    = {{tamanyo{res_q[tamanyo-1]}}, res_q};
  assign fix_sum    = acc_signed + res_ext;
  assign fix_top    = fix_sum[2*tamanyo-1:tamanyo-1];
  assign fix_ovf    = ~((&fix_top) | ~(|fix_top));

  assign Done      = (state == DONE);
  assign dbg_state = state;

  // State register; reset forces IDLE immediately.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (Start)            state_next = MULT;
      MULT: if (cnt == last_iter) state_next = FIX;
      FIX:                        state_next = DONE;
      DONE: if (!Start)           state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, run the shift-add iterations, load the result.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      res_q  <= '0;
      Num    <= '0;
      Ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mcand  <= {{tamanyo{1'b0}}, coc_mag};
            mplr   <= den_mag;
            sign_q <= Coc[tamanyo-1] ^ Den[tamanyo-1];
            res_q  <= Res;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MULT: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          Num <= fix_sum;
          Ovf <= fix_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// Bench for multiplicador_algoritmico (tamanyo = 16).
// The driver issues requests and pushes the expected Num/Ovf, computed as
// plain integer Coc*Den+Res. A monitor pops and compares on each rising Done.
module tb_multiplicador_algoritmico;

  localparam int W = 16;

  logic            CLK;
  logic            RSTa;
  logic            Start;
  logic [W-1:0]    Coc;
  logic [W-1:0]    Den;
  logic [W-1:0]    Res;
  logic [2*W-1:0]  Num;
  logic            Done;
  logic            Ovf;
  logic [1:0]      dbg_state;

  int tests = 0;
  int fails = 0;

  logic [2*W-1:0] exp_q[$];
  logic           exp_ovf_q[$];

  multiplicador_algoritmico #(.tamanyo(W)) dut (
    .CLK       (CLK),
    .RSTa      (RSTa),
    .Start     (Start),
    .Coc       (Coc),
    .Den       (Den),
    .Res       (Res),
    .Num       (Num),
    .Done      (Done),
    .Ovf       (Ovf),
    .dbg_state (dbg_state)
  );

  // Clock: 10 time-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
    end
  endtask

  // Monitor: compare the result on each rising Done, away from the active edge.
  logic done_prev = 1'b0;
  always @(negedge CLK) begin
    if (Done && !done_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: Num 0x%0h with no pending request", Num);
      end else begin
        automatic logic [2*W-1:0] en = exp_q.pop_front();
        automatic logic           eo = exp_ovf_q.pop_front();
        check("num", 64'(Num), 64'(en));
        check("ovf", 64'(Ovf), 64'(eo));
      end
    end
    done_prev = Done;
  end

  // Driver. Issues one request and checks latency and the Done level.
  // Latency counts the Start-sampling edge as edge 1, so Done must
  // first appear high after edge 18.
  // hold > 0 keeps Start high for that many cycles in DONE.
  // scramble changes the operand inputs while MULT is running.
  task automatic do_op(input logic signed [W-1:0] c, input logic signed [W-1:0] d,
                       input logic signed [W-1:0] r, input int hold, input bit scramble);
    longint e;
    int     n;
    bit     seen;
    e = longint'(c) * longint'(d) + longint'(r);
    exp_q.push_back(32'(e));
    exp_ovf_q.push_back((e > 32767) || (e < -32768));
    @(negedge CLK);
    Coc = c; Den = d; Res = r; Start = 1'b1;
    @(posedge CLK);
    n = 1;
    @(negedge CLK);
    if (hold == 0) Start = 1'b0;
    if (scramble) begin
      Coc = W'($urandom);
      Den = W'($urandom);
      Res = W'($urandom);
    end
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge CLK);
      n++;
      #1;
      if (Done) seen = 1'b1;
    end
    check("done_latency", 64'(n), 64'(18));
    if (!seen) return;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      #1;
      check("done_hold", 64'(Done), 64'(1));
    end
    if (hold > 0) begin
      @(negedge CLK);
      Start = 1'b0;
    end
    @(posedge CLK);
    #1;
    check("done_clear", 64'(Done), 64'(0));
    check("back_to_idle", 64'(dbg_state), 64'(0));
  endtask

  logic signed [W-1:0] tc[14];
  logic signed [W-1:0] td[14];
  logic signed [W-1:0] tr[14];

  initial begin
    // Directed cases: basic products, sign mixes, the divider replays,
    // overflow limits and zero operands.
    tc = '{16'sd5,  -16'sd5, 16'sd4,  16'sd5,  16'sd5,  16'sd5,  -16'sd5,
           -16'sd5, 16'sd5,  16'sd4,  -16'sd6, -16'sd32768, 16'sd0, 16'sd7};
    td = '{16'sd3,  16'sd3,  -16'sd5, -16'sd3, 16'sd3,  -16'sd3, -16'sd3,
           16'sd3,  -16'sd3, -16'sd5, 16'sd3,  -16'sd1, 16'sd99, 16'sd0};
    tr = '{16'sd0,  -16'sd2, -16'sd3, 16'sd2,  16'sd2,  16'sd0,  16'sd0,
           16'sd0,  16'sd2,  -16'sd3, 16'sd0,  16'sd0,  -16'sd7, 16'sd123};

    RSTa = 1'b1; Start = 1'b0; Coc = '0; Den = '0; Res = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_num", 64'(Num), 64'(0));
    check("rst_done", 64'(Done), 64'(0));
    check("rst_ovf", 64'(Ovf), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    @(negedge CLK);
    RSTa = 1'b0;

    for (int i = 0; i < 14; i++) do_op(tc[i], td[i], tr[i], 0, 1'b0);
    do_op(16'sd32767, 16'sd32767, 16'sd32767, 0, 1'b0);

    // Start held through DONE while the operands change during MULT.
    do_op(16'sd5, 16'sd3, 16'sd0, 4, 1'b1);
    do_op(-16'sd32768, -16'sd1, 16'sd0, 2, 1'b1);

    // Reset at MULT iteration 7. The outputs of the previous result,
    // Num=32768 and Ovf=1, must clear at once.
    @(negedge CLK);
    Coc = 16'd1000; Den = 16'd77; Res = 16'd5; Start = 1'b1;
    @(posedge CLK);
    repeat (8) @(posedge CLK);
    #2;
    RSTa = 1'b1;
    #1;
    check("abort_num", 64'(Num), 64'(0));
    check("abort_done", 64'(Done), 64'(0));
    check("abort_ovf", 64'(Ovf), 64'(0));
    check("abort_state", 64'(dbg_state), 64'(0));
    Start = 1'b0;
    @(posedge CLK);
    #2;
    RSTa = 1'b0;
    do_op(16'sd1000, 16'sd77, 16'sd5, 0, 1'b0);

    // Randomized requests, with occasional extreme values.
    for (int i = 0; i < 30; i++) begin
      logic signed [W-1:0] c, d, r;
      c = W'($urandom);
      d = W'($urandom);
      r = W'($urandom);
      if ($urandom_range(0, 7) == 0) c = -16'sd32768;
      if ($urandom_range(0, 7) == 0) d = 16'sd0;
      do_op(c, d, r, $urandom_range(0, 2), 1'(($urandom_range(0, 1))));
    end

    repeat (3) @(posedge CLK);
    check("pending_results", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
